// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core bus arbiter.
// Bus widths, size and response codes, request encoding.
package core_bus_arbiter_pkg;

    localparam int DATA_BUS = 64;
    localparam int ADDR_BUS = 64;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/core_bus_arbiter.sv
// Two-master (fetch, data) to one-slave core bus arbiter.
// Optional watchdog: define CORE_BUS_ARB_TIMEOUT_EN.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int DATA_W         = DATA_BUS,
    parameter int ADDR_W         = ADDR_BUS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [1:0]        if_size_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_data_read_o,
    output logic [1:0]        if_resp_o,
    input  logic              mem_valid_i,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [DATA_W-1:0] mem_data_write_i,
    output logic              mem_ready_o,
    output logic [DATA_W-1:0] mem_data_read_o,
    output logic [1:0]        mem_resp_o,
    output logic              bus_valid_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [1:0]        bus_size_o,
    output logic [DATA_W-1:0] bus_data_write_o,
    input  logic              bus_ready_i,
    input  logic [DATA_W-1:0] bus_data_read_i,
    input  logic [1:0]        bus_resp_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_e;

    state_e state;
    state_e state_nx;
    logic   ld_if;
    logic   ld_mem;
    logic   drop;
    logic   timeout;

`ifdef CORE_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             granted;

    assign granted = (state != IDLE);
    assign timeout = granted && !bus_ready_i
                  && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog: count stalled granted cycles, restart per grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (ld_if || ld_mem) begin
            wd_cnt <= '0;
        end else if (granted && !bus_ready_i && !timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    // No watchdog in this build; a grant waits forever.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arbitration: MEM first from idle, completed master excluded.
    always_comb begin
        state_nx = state;
        ld_if    = 1'b0;
        ld_mem   = 1'b0;
        drop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_valid_i) begin
                    state_nx = GNT_MEM;
                    ld_mem   = 1'b1;
                end else if (if_valid_i) begin
                    state_nx = GNT_IF;
                    ld_if    = 1'b1;
                end
            end
            GNT_MEM: begin
                if (bus_ready_i && if_valid_i) begin
                    state_nx = GNT_IF;
                    ld_if    = 1'b1;
                end else if (bus_ready_i || timeout) begin
                    state_nx = IDLE;
                    drop     = 1'b1;
                end
            end
            GNT_IF: begin
                if (bus_ready_i && mem_valid_i) begin
                    state_nx = GNT_MEM;
                    ld_mem   = 1'b1;
                end else if (bus_ready_i || timeout) begin
                    state_nx = IDLE;
                    drop     = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture the winner's request fields on the grant edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_valid_o      <= 1'b0;
            bus_req_o        <= 1'b0;
            bus_addr_o       <= '0;
            bus_size_o       <= 2'b00;
            bus_data_write_o <= '0;
        end else if (ld_mem) begin
            bus_valid_o      <= 1'b1;
            bus_req_o        <= mem_req_i;
            bus_addr_o       <= mem_addr_i;
            bus_size_o       <= mem_size_i;
            bus_data_write_o <= mem_data_write_i;
        end else if (ld_if) begin
            bus_valid_o      <= 1'b1;
            bus_req_o        <= REQ_READ;
            bus_addr_o       <= if_addr_i;
            bus_size_o       <= if_size_i;
            bus_data_write_o <= '0;
        end else if (drop) begin
            bus_valid_o      <= 1'b0;
        end
    end

    // Route the downstream return to the granted master only.
    always_comb begin
        if_ready_o      = 1'b0;
        if_data_read_o  = '0;
        if_resp_o       = RESP_OKAY;
        mem_ready_o     = 1'b0;
        mem_data_read_o = '0;
        mem_resp_o      = RESP_OKAY;
        unique case (state)
            GNT_IF: begin
                if_ready_o     = bus_ready_i | timeout;
                if_data_read_o = timeout ? '0 : bus_data_read_i;
                if_resp_o      = timeout ? RESP_ERR : bus_resp_i;
            end
            GNT_MEM: begin
                mem_ready_o     = bus_ready_i | timeout;
                mem_data_read_o = timeout ? '0 : bus_data_read_i;
                mem_resp_o      = timeout ? RESP_ERR : bus_resp_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Randomized self-checking bench for core_bus_arbiter.
// Timeout checks active with CORE_BUS_ARB_TIMEOUT_EN.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_valid_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic [1:0]    if_size_i = 2'b00;
    logic          if_ready_o;
    logic [DW-1:0] if_data_read_o;
    logic [1:0]    if_resp_o;
    logic          mem_valid_i = 1'b0;
    logic          mem_req_i = 1'b0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [1:0]    mem_size_i = 2'b00;
    logic [DW-1:0] mem_data_write_i = '0;
    logic          mem_ready_o;
    logic [DW-1:0] mem_data_read_o;
    logic [1:0]    mem_resp_o;
    logic          bus_valid_o;
    logic          bus_req_o;
    logic [AW-1:0] bus_addr_o;
    logic [1:0]    bus_size_o;
    logic [DW-1:0] bus_data_write_o;
    logic          bus_ready_i = 1'b0;
    logic [DW-1:0] bus_data_read_i = '0;
    logic [1:0]    bus_resp_i = 2'b00;

    always #5 clk = ~clk;

    core_bus_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_addr_i(if_addr_i),
        .if_size_i(if_size_i), .if_ready_o(if_ready_o),
        .if_data_read_o(if_data_read_o), .if_resp_o(if_resp_o),
        .mem_valid_i(mem_valid_i), .mem_req_i(mem_req_i),
        .mem_addr_i(mem_addr_i), .mem_size_i(mem_size_i),
        .mem_data_write_i(mem_data_write_i),
        .mem_ready_o(mem_ready_o),
        .mem_data_read_o(mem_data_read_o), .mem_resp_o(mem_resp_o),
        .bus_valid_o(bus_valid_o), .bus_req_o(bus_req_o),
        .bus_addr_o(bus_addr_o), .bus_size_o(bus_size_o),
        .bus_data_write_o(bus_data_write_o),
        .bus_ready_i(bus_ready_i),
        .bus_data_read_i(bus_data_read_i), .bus_resp_i(bus_resp_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: who holds the bus (0 none, 1 fetch, 2 data)
    // and the request it was granted with.
    int          owner  = 0;
    int          m_wait = 0;
    logic        m_valid = 1'b0;
    logic        m_req   = 1'b0;
    logic [63:0] m_addr  = '0;
    logic [1:0]  m_size  = 2'b00;
    logic [63:0] m_wdata = '0;
    logic        got_if  = 1'b0;
    logic        got_mem = 1'b0;

    task automatic grant_mem();
        owner   = 2;
        m_valid = 1'b1;
        m_req   = mem_req_i;
        m_addr  = mem_addr_i;
        m_size  = mem_size_i;
        m_wdata = mem_data_write_i;
        m_wait  = 0;
    endtask

    task automatic grant_if();
        owner   = 1;
        m_valid = 1'b1;
        m_req   = 1'b0;
        m_addr  = if_addr_i;
        m_size  = if_size_i;
        m_wdata = '0;
        m_wait  = 0;
    endtask

    task automatic model_reset();
        owner   = 0;
        m_wait  = 0;
        m_valid = 1'b0;
    endtask

    task automatic reset_chk();
        check("rst_bus_valid", bus_valid_o, 0);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_addr", bus_addr_o, 0);
        check("rst_bus_size", bus_size_o, 0);
        check("rst_bus_wdata", bus_data_write_o, 0);
        check("rst_if_ready", if_ready_o, 0);
        check("rst_mem_ready", mem_ready_o, 0);
    endtask

    // One clock: check DUT against the reference, then advance both.
    task automatic step();
        bit          tmo;
        bit          done;
        int          last;
        logic [63:0] ed;
        logic [1:0]  er;
        #1;
        tmo = 1'b0;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
        tmo = (owner != 0) && !bus_ready_i && (m_wait == TO);
`endif
        done = (owner != 0) && (bus_ready_i || tmo);
        ed = tmo ? 64'h0 : bus_data_read_i;
        er = tmo ? RESP_ERR : bus_resp_i;
        check("bus_valid", bus_valid_o, m_valid);
        if (m_valid) begin
            check("bus_req", bus_req_o, m_req);
            check("bus_addr", bus_addr_o, m_addr);
            check("bus_size", bus_size_o, m_size);
            check("bus_wdata", bus_data_write_o, m_wdata);
        end
        check("if_ready", if_ready_o, owner == 1 && done);
        check("mem_ready", mem_ready_o, owner == 2 && done);
        if (owner == 1) begin
            check("if_data", if_data_read_o, ed);
            check("if_resp", if_resp_o, er);
            check("mem_data_idle", mem_data_read_o, 0);
            check("mem_resp_idle", mem_resp_o, 0);
        end else if (owner == 2) begin
            check("mem_data", mem_data_read_o, ed);
            check("mem_resp", mem_resp_o, er);
            check("if_data_idle", if_data_read_o, 0);
            check("if_resp_idle", if_resp_o, 0);
        end
        got_if  = if_ready_o;
        got_mem = mem_ready_o;
        if (owner == 0) begin
            if (mem_valid_i) grant_mem();
            else if (if_valid_i) grant_if();
        end else if (done) begin
            last    = owner;
            owner   = 0;
            m_valid = 1'b0;
            if (!tmo) begin
                if (last == 2 && if_valid_i) grant_if();
                else if (last == 1 && mem_valid_i) grant_mem();
            end
        end else begin
            m_wait++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        @(posedge clk);
        #1;
        reset_chk();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fetch alone.
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0000;
        if_size_i  = SIZE_W;
        step();
        step();
        step();
        bus_ready_i     = 1'b1;
        bus_data_read_i = 64'h13;
        bus_resp_i      = RESP_OKAY;
        step();
        if_valid_i  = 1'b0;
        bus_ready_i = 1'b0;
        step();

        // Simultaneous requests, then field stability.
        if_valid_i       = 1'b1;
        if_addr_i        = 64'h8000_0040;
        mem_valid_i      = 1'b1;
        mem_req_i        = REQ_WRITE;
        mem_addr_i       = 64'h8000_1000;
        mem_size_i       = SIZE_D;
        mem_data_write_i = 64'hDEAD_BEEF;
        step();
        check("simul_mem_first", bus_req_o, 1);
        mem_addr_i       = 64'h0;
        mem_data_write_i = rnd64();
        step();
        step();
        bus_ready_i     = 1'b1;
        bus_data_read_i = rnd64();
        step();
        check("simul_if_next", bus_valid_o, 1);
        check("simul_if_req", bus_req_o, 0);
        mem_valid_i = 1'b0;
        bus_ready_i = 1'b0;
        step();
        bus_ready_i = 1'b1;
        step();
        if_valid_i  = 1'b0;
        bus_ready_i = 1'b0;
        step();

        // Alternation with both masters held valid.
        if_valid_i  = 1'b1;
        mem_valid_i = 1'b1;
        mem_req_i   = REQ_WRITE;
        step();
        for (int i = 0; i < 4; i++) begin
            check("alt_order", bus_req_o, (i % 2 == 0) ? 1 : 0);
            bus_ready_i = 1'b0;
            step();
            bus_ready_i = 1'b1;
            step();
        end
        if_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        bus_ready_i = 1'b0;
        step();

        // Reset in the middle of a data grant.
        mem_valid_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_async_valid", bus_valid_o, 0);
        check("rst_async_ready", mem_ready_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_chk();
        rst         = 1'b1;
        mem_valid_i = 1'b0;
        bus_ready_i = 1'b1;
        step();
        bus_ready_i = 1'b0;
        step();

`ifdef CORE_BUS_ARB_TIMEOUT_EN
        // Watchdog: data grant with a silent slave.
        mem_valid_i = 1'b1;
        mem_req_i   = REQ_READ;
        step();
        n = 0;
        got_mem = 1'b0;
        while (!got_mem && n < 20) begin
            step();
            n++;
        end
        check("to_latency", n, TO + 1);
        mem_valid_i = 1'b0;
        step();
        check("to_valid_drop", bus_valid_o, 0);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!if_valid_i && owner != 1) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_valid_i = 1'b1;
                    if_addr_i  = rnd64();
                    if_size_i  = 2'($urandom);
                end
            end else if (owner == 1) begin
                if ($urandom_range(0, 3) == 0) if_addr_i = rnd64();
                if ($urandom_range(0, 15) == 0) if_valid_i = 1'b0;
            end
            if (!mem_valid_i && owner != 2) begin
                if ($urandom_range(0, 2) == 0) begin
                    mem_valid_i      = 1'b1;
                    mem_req_i        = 1'($urandom);
                    mem_addr_i       = rnd64();
                    mem_size_i       = 2'($urandom);
                    mem_data_write_i = rnd64();
                end
            end else if (owner == 2) begin
                if ($urandom_range(0, 3) == 0) begin
                    mem_addr_i       = rnd64();
                    mem_data_write_i = rnd64();
                    mem_req_i        = 1'($urandom);
                end
                if ($urandom_range(0, 15) == 0) mem_valid_i = 1'b0;
            end
            if (owner != 0) bus_ready_i = ($urandom_range(0, 3) == 0);
            else bus_ready_i = ($urandom_range(0, 7) == 0);
            bus_data_read_i = rnd64();
            bus_resp_i = $urandom_range(0, 1) ? RESP_ERR : RESP_OKAY;
            step();
            if (got_if) if_valid_i = 1'b0;
            if (got_mem) mem_valid_i = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
